// File: rtl/snake_body_tracker.sv
// Snake body tracker: keeps the segment list of a snake on a 16x16 grid, evaluates
// one move per tick and reports apple pickups, border/self collisions and the win.
module snake_body_tracker #(
  parameter int MAX_LENGTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_reset,
  input  logic                            tick,
  input  logic [1:0]                      dir,
  input  logic [7:0]                      apple_cord,
  output logic [8*MAX_LENGTH-1:0]         body,
  output logic [$clog2(MAX_LENGTH+1)-1:0] length,
  output logic                            goodColl,
  output logic                            badColl,
  output logic                            win
);
  localparam int LW = $clog2(MAX_LENGTH+1);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {ST_RUN, ST_OVER, ST_WIN} state_t;

  state_t        state;
  logic [1:0]    heading;
  logic [1:0]    heading_nxt;
  logic [7:0]    seg [MAX_LENGTH];
  logic [3:0]    head_x;
  logic [3:0]    head_y;
  logic [7:0]    next_head;
  logic          grow;
  logic          border_hit;
  logic          self_hit;
  logic [LW-1:0] hit_limit;
  logic [LW-1:0] shift_limit;

  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    heading_nxt = (dir == (heading ^ 2'b01)) ? heading : dir;
    head_x      = seg[0][7:4];
    head_y      = seg[0][3:0];
    case (heading_nxt)
      DIR_UP:   head_y = seg[0][3:0] - 4'd1;
      DIR_DOWN: head_y = seg[0][3:0] + 4'd1;
      DIR_LEFT: head_x = seg[0][7:4] - 4'd1;
      default:  head_x = seg[0][7:4] + 4'd1;
    endcase
    next_head  = {head_x, head_y};
    border_hit = (head_x == 4'h0) || (head_x == 4'hF) || (head_y == 4'h0) || (head_y == 4'hF);
    grow       = (next_head == apple_cord);
    // The tail cell vacates on a plain move, but stays occupied when growing.
    hit_limit   = grow ? length : length - LW'(1);
    shift_limit = length + LW'(grow);
    self_hit    = 1'b0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if ((LW'(i) < hit_limit) && (seg[i] == next_head)) self_hit = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every read sees the pre-edge value.
  // NOTE: the segment array is reset explicitly; its reset contents are the starting snake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      heading  <= DIR_RIGHT;
      length   <= LW'(2);
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      win      <= 1'b0;
      for (int i = 0; i < MAX_LENGTH; i++) seg[i] <= (i == 0) ? 8'h88 : (i == 1) ? 8'h78 : 8'h00;
    end else if (s_reset) begin
      state    <= ST_RUN;
      heading  <= DIR_RIGHT;
      length   <= LW'(2);
      goodColl <= 1'b0;
      badColl  <= 1'b0;
      win      <= 1'b0;
      for (int i = 0; i < MAX_LENGTH; i++) seg[i] <= (i == 0) ? 8'h88 : (i == 1) ? 8'h78 : 8'h00;
    end else begin
      goodColl <= 1'b0;
      if (tick && (state == ST_RUN)) begin
        if (border_hit || self_hit) begin
          state   <= ST_OVER;
          badColl <= 1'b1;
        end else begin
          heading <= heading_nxt;
          seg[0]  <= next_head;
          for (int i = 1; i < MAX_LENGTH; i++) begin
            if (LW'(i) < shift_limit) seg[i] <= seg[i-1];
          end
          if (grow) begin
            length   <= length + LW'(1);
            goodColl <= 1'b1;
            if (length + LW'(1) == LW'(MAX_LENGTH)) begin
              state <= ST_WIN;
              win   <= 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < MAX_LENGTH; g++) begin : g_pack
    assign body[8*g +: 8] = seg[g];
  end

endmodule
